// File: rtl/csa_pkg.sv
// Shared types and constants for the CSA block-decipher core.
// Round count, byte/block types, FSM states and the bit permutation map.
package csa_pkg;

    localparam int ROUNDS = 56;

    typedef logic [7:0] byte_t;
    typedef byte_t [7:0] blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // PERM[i] is the output bit position that input bit i moves to
    localparam logic [2:0] PERM [8] = '{
        3'd1, 3'd7, 3'd5, 3'd4, 3'd2, 3'd6, 3'd0, 3'd3
    };

endpackage

// File: rtl/block_sbox.sv
// CSA block-cipher S-box: combinational 8-bit table lookup.
module block_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h3a,8'hea,8'h68,8'hfe,8'h33,8'he9,8'h88,8'h1a,
        8'h83,8'hcf,8'he1,8'h7f,8'hba,8'he2,8'h38,8'h12,
        8'he8,8'h27,8'h61,8'h95,8'h0c,8'h36,8'he5,8'h70,
        8'ha2,8'h06,8'h82,8'h7c,8'h17,8'ha3,8'h26,8'h49,
        8'hbe,8'h7a,8'h6d,8'h47,8'hc1,8'h51,8'h8f,8'hf3,
        8'hcc,8'h5b,8'h67,8'hbd,8'hcd,8'h18,8'h08,8'hc9,
        8'hff,8'h69,8'hef,8'h03,8'h4e,8'h48,8'h4a,8'h84,
        8'h3f,8'hb4,8'h10,8'h04,8'hdc,8'hf5,8'h5c,8'hc6,
        8'h16,8'hab,8'hac,8'h4c,8'hf1,8'h6a,8'h2f,8'h3c,
        8'h3b,8'hd4,8'hd5,8'h94,8'hd0,8'hc4,8'h63,8'h62,
        8'h71,8'ha1,8'hf9,8'h4f,8'h2e,8'haa,8'hc5,8'h56,
        8'he3,8'h39,8'h93,8'hce,8'h65,8'h64,8'he4,8'h58,
        8'h6c,8'h19,8'h42,8'h79,8'hdd,8'hee,8'h96,8'hf6,
        8'h8a,8'hec,8'h1e,8'h85,8'h53,8'h45,8'hde,8'hbb,
        8'h7e,8'h0a,8'h9a,8'h13,8'h2a,8'h9d,8'hc2,8'h5e,
        8'h5a,8'h1f,8'h32,8'h35,8'h9c,8'ha8,8'h73,8'h30,
        8'h29,8'h3d,8'he7,8'h92,8'h87,8'h1b,8'h2b,8'h4b,
        8'ha5,8'h57,8'h97,8'h40,8'h15,8'he6,8'hbc,8'h0e,
        8'heb,8'hc3,8'h34,8'h2d,8'hb8,8'h44,8'h25,8'ha4,
        8'h1c,8'hc7,8'h23,8'hed,8'h90,8'h6e,8'h50,8'h00,
        8'h99,8'h9e,8'h4d,8'hd9,8'hda,8'h8d,8'h6f,8'h5f,
        8'h3e,8'hd7,8'h21,8'h74,8'h86,8'hdf,8'h6b,8'h05,
        8'h8e,8'h5d,8'h37,8'h11,8'hd2,8'h28,8'h75,8'hd6,
        8'ha7,8'h77,8'h24,8'hbf,8'hf0,8'hb0,8'h02,8'hb7,
        8'hf8,8'hfc,8'h81,8'h09,8'hb1,8'h01,8'h76,8'h91,
        8'h7d,8'h0f,8'hc8,8'ha0,8'hf2,8'hcb,8'h78,8'h60,
        8'hd1,8'hf7,8'he0,8'hb5,8'h98,8'h22,8'hb3,8'h20,
        8'h1d,8'ha6,8'hdb,8'h7b,8'h59,8'h9f,8'hae,8'h31,
        8'hfb,8'hd3,8'hb6,8'hca,8'h43,8'h72,8'h07,8'hf4,
        8'hd8,8'h41,8'h14,8'h55,8'h0d,8'h54,8'h8b,8'hb9,
        8'had,8'h46,8'h0b,8'haf,8'h80,8'h52,8'h2c,8'hfa,
        8'h8c,8'h89,8'h66,8'hfd,8'hb2,8'ha9,8'h9b,8'hc0
    };

    assign y = SBOX[x];

endmodule

// File: rtl/block_decypher_core.sv
// Iterative CSA block decipher: 56 rounds over an 8-byte state.
// Define BLOCK_DECYPHER_UNROLL2_EN to run two rounds per clock.
module block_decypher_core
    import csa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*ROUNDS-1:0]   kk,
    input  logic [63:0]           in_block,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [63:0]           out_block,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_t                  state_q;
    state_t                  state_d;
    blk_t                    w_q;
    byte_t [ROUNDS-1:0]      k_q;
    logic [5:0]              rnd_q;
    logic                    accept;
    logic                    last;
    blk_t                    w_nx;

    function automatic byte_t perm(byte_t s);
        byte_t p;
        p = '0;
        for (int b = 0; b < 8; b++) begin
            p[PERM[b]] = s[3'(b)];
        end
        return p;
    endfunction

    function automatic blk_t step(blk_t w, byte_t s);
        blk_t  n;
        byte_t l;
        l    = w[7] ^ s;
        n[7] = w[6];
        n[6] = w[5] ^ perm(s);
        n[5] = w[4];
        n[4] = w[3] ^ l;
        n[3] = w[2] ^ l;
        n[2] = w[1] ^ l;
        n[1] = w[0];
        n[0] = l;
        return n;
    endfunction

    byte_t x0;
    byte_t s0;
    blk_t  w1;

    assign x0 = k_q[rnd_q] ^ w_q[6];

    block_sbox u_sbox0 (
        .x (x0),
        .y (s0)
    );

    assign w1 = step(w_q, s0);

`ifdef BLOCK_DECYPHER_UNROLL2_EN
    localparam logic [5:0] STEP = 6'd2;

    byte_t x1;
    byte_t s1;

    // second round uses key byte rnd-1; rnd is always odd here
    assign x1 = k_q[rnd_q - 6'd1] ^ w1[6];

    block_sbox u_sbox1 (
        .x (x1),
        .y (s1)
    );

    assign w_nx = step(w1, s1);
    assign last = (rnd_q == 6'd1);
`else
    localparam logic [5:0] STEP = 6'd1;

    assign w_nx = w1;
    assign last = (rnd_q == 6'd0);
`endif

    assign accept = (state_q == IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        out_block = out_valid ? w_q : 64'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q   <= '0;
            k_q   <= '0;
            rnd_q <= '0;
        end else if (accept) begin
            w_q   <= in_block;
            k_q   <= kk;
            rnd_q <= 6'(ROUNDS - 1);
        end else if (state_q == RUN) begin
            w_q <= w_nx;
            // counter parks at its final value instead of wrapping
            if (!last) begin
                rnd_q <= rnd_q - STEP;
            end
        end
    end

endmodule

// File: tb/tb_block_decypher_core.sv
// Self-checking bench for block_decypher_core.
// Randomized blocks checked against a byte-level model of the decipher.
module tb_block_decypher_core;

    localparam int NR = 56;
`ifdef BLOCK_DECYPHER_UNROLL2_EN
    localparam int LAT = NR / 2;
`else
    localparam int LAT = NR;
`endif

    localparam logic [7:0] SB [256] = '{
        8'h3a,8'hea,8'h68,8'hfe,8'h33,8'he9,8'h88,8'h1a,
        8'h83,8'hcf,8'he1,8'h7f,8'hba,8'he2,8'h38,8'h12,
        8'he8,8'h27,8'h61,8'h95,8'h0c,8'h36,8'he5,8'h70,
        8'ha2,8'h06,8'h82,8'h7c,8'h17,8'ha3,8'h26,8'h49,
        8'hbe,8'h7a,8'h6d,8'h47,8'hc1,8'h51,8'h8f,8'hf3,
        8'hcc,8'h5b,8'h67,8'hbd,8'hcd,8'h18,8'h08,8'hc9,
        8'hff,8'h69,8'hef,8'h03,8'h4e,8'h48,8'h4a,8'h84,
        8'h3f,8'hb4,8'h10,8'h04,8'hdc,8'hf5,8'h5c,8'hc6,
        8'h16,8'hab,8'hac,8'h4c,8'hf1,8'h6a,8'h2f,8'h3c,
        8'h3b,8'hd4,8'hd5,8'h94,8'hd0,8'hc4,8'h63,8'h62,
        8'h71,8'ha1,8'hf9,8'h4f,8'h2e,8'haa,8'hc5,8'h56,
        8'he3,8'h39,8'h93,8'hce,8'h65,8'h64,8'he4,8'h58,
        8'h6c,8'h19,8'h42,8'h79,8'hdd,8'hee,8'h96,8'hf6,
        8'h8a,8'hec,8'h1e,8'h85,8'h53,8'h45,8'hde,8'hbb,
        8'h7e,8'h0a,8'h9a,8'h13,8'h2a,8'h9d,8'hc2,8'h5e,
        8'h5a,8'h1f,8'h32,8'h35,8'h9c,8'ha8,8'h73,8'h30,
        8'h29,8'h3d,8'he7,8'h92,8'h87,8'h1b,8'h2b,8'h4b,
        8'ha5,8'h57,8'h97,8'h40,8'h15,8'he6,8'hbc,8'h0e,
        8'heb,8'hc3,8'h34,8'h2d,8'hb8,8'h44,8'h25,8'ha4,
        8'h1c,8'hc7,8'h23,8'hed,8'h90,8'h6e,8'h50,8'h00,
        8'h99,8'h9e,8'h4d,8'hd9,8'hda,8'h8d,8'h6f,8'h5f,
        8'h3e,8'hd7,8'h21,8'h74,8'h86,8'hdf,8'h6b,8'h05,
        8'h8e,8'h5d,8'h37,8'h11,8'hd2,8'h28,8'h75,8'hd6,
        8'ha7,8'h77,8'h24,8'hbf,8'hf0,8'hb0,8'h02,8'hb7,
        8'hf8,8'hfc,8'h81,8'h09,8'hb1,8'h01,8'h76,8'h91,
        8'h7d,8'h0f,8'hc8,8'ha0,8'hf2,8'hcb,8'h78,8'h60,
        8'hd1,8'hf7,8'he0,8'hb5,8'h98,8'h22,8'hb3,8'h20,
        8'h1d,8'ha6,8'hdb,8'h7b,8'h59,8'h9f,8'hae,8'h31,
        8'hfb,8'hd3,8'hb6,8'hca,8'h43,8'h72,8'h07,8'hf4,
        8'hd8,8'h41,8'h14,8'h55,8'h0d,8'h54,8'h8b,8'hb9,
        8'had,8'h46,8'h0b,8'haf,8'h80,8'h52,8'h2c,8'hfa,
        8'h8c,8'h89,8'h66,8'hfd,8'hb2,8'ha9,8'h9b,8'hc0
    };

    logic              clk;
    logic              rst;
    logic [8*NR-1:0]   kk;
    logic [63:0]       in_block;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       out_block;
    logic              out_valid;
    logic              out_ready;

    int tests;
    int fails;

    block_decypher_core dut (
        .clk       (clk),
        .rst       (rst),
        .kk        (kk),
        .in_block  (in_block),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [8*NR-1:0] k,
                                          input logic [63:0] blk);
        logic [7:0] w [8];
        logic [7:0] n [8];
        logic [7:0] s;
        logic [7:0] l;
        logic [7:0] p;
        logic [63:0] r;
        for (int j = 0; j < 8; j++) w[j] = blk[8*j +: 8];
        for (int i = NR - 1; i >= 0; i--) begin
            s = SB[k[8*i +: 8] ^ w[6]];
            l = w[7] ^ s;
            p = {s[1], s[5], s[2], s[3], s[7], s[4], s[0], s[6]};
            n[0] = l;
            n[1] = w[0];
            n[2] = w[1] ^ l;
            n[3] = w[2] ^ l;
            n[4] = w[3] ^ l;
            n[5] = w[4];
            n[6] = w[5] ^ p;
            n[7] = w[6];
            w = n;
        end
        for (int j = 0; j < 8; j++) r[8*j +: 8] = w[j];
        return r;
    endfunction

    function automatic logic [8*NR-1:0] rand_kk();
        logic [8*NR-1:0] r;
        for (int i = 0; i < NR / 4; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rand_blk();
        return {$urandom, $urandom};
    endfunction

    task automatic accept_block(input logic [8*NR-1:0] k,
                                input logic [63:0] b,
                                output logic rdy);
        @(negedge clk);
        kk       = k;
        in_block = b;
        in_valid = 1'b1;
        #1 rdy = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_block();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        kk        = '0;
        in_block  = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: in_ready=%b out_valid=%b want 0 0",
                     in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 64'h0) begin
            fails++;
            $display("FAIL reset_release: rdy=%b vld=%b blk=%h want 1 0 0",
                     in_ready, out_valid, out_block);
        end
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 64'h0)
                bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL idle_stable: rdy=%b vld=%b blk=%h want 1 0 0",
                     in_ready, out_valid, out_block);
        end
    endtask

    task automatic test_golden();
        logic [8*NR-1:0] k;
        logic [63:0]     b;
        logic [63:0]     exp;
        logic            rdy;
        int              lat;
        for (int v = 0; v < 2; v++) begin
            if (v == 0) begin
                k = '0;
                b = 64'h0;
            end else begin
                for (int i = 0; i < NR; i++) k[8*i +: 8] = 8'(i);
                b = 64'h0123456789ABCDEF;
            end
            exp = model(k, b);
            accept_block(k, b, rdy);
            tests++;
            if (rdy !== 1'b1) begin
                fails++;
                $display("FAIL golden%0d_ready: in_ready=%b want 1", v, rdy);
            end
            wait_done(lat);
            tests++;
            if (lat != LAT) begin
                fails++;
                $display("FAIL golden%0d_latency: got %0d want %0d", v, lat, LAT);
            end
            tests++;
            if (out_block !== exp) begin
                fails++;
                $display("FAIL golden%0d_data: got %h want %h", v, out_block, exp);
            end
            release_block();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL golden%0d_handshake: vld=%b rdy=%b want 0 1",
                         v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8*NR-1:0] k;
        logic [63:0]     b;
        logic [63:0]     exp;
        logic            rdy;
        logic            bad;
        int              lat;
        k   = rand_kk();
        b   = rand_blk();
        exp = model(k, b);
        accept_block(k, b, rdy);
        wait_done(lat);
        bad = (lat < 0);
        repeat (10) begin
            @(negedge clk);
            kk       = rand_kk();
            in_block = rand_blk();
            in_valid = 1'b1;
            #1;
            if (out_valid !== 1'b1 || out_block !== exp || in_ready !== 1'b0)
                bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL backpressure_hold: vld=%b rdy=%b blk=%h want 1 0 %h",
                     out_valid, in_ready, out_block, exp);
        end
        in_valid = 1'b0;
        release_block();
        k   = rand_kk();
        b   = rand_blk();
        exp = model(k, b);
        accept_block(k, b, rdy);
        tests++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_resume: in_ready=%b want 1", rdy);
        end
        wait_done(lat);
        tests++;
        if (lat != LAT || out_block !== exp) begin
            fails++;
            $display("FAIL backpressure_next: lat=%0d blk=%h want %0d %h",
                     lat, out_block, LAT, exp);
        end
        release_block();
    endtask

    task automatic test_isolation();
        logic [8*NR-1:0] k;
        logic [63:0]     b;
        logic [63:0]     exp;
        logic            rdy;
        int              lat;
        k   = rand_kk();
        b   = rand_blk();
        exp = model(k, b);
        accept_block(k, b, rdy);
        repeat (LAT - 4) begin
            @(negedge clk);
            kk       = rand_kk();
            in_block = rand_blk();
            in_valid = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        tests++;
        if (lat < 0 || out_block !== exp) begin
            fails++;
            $display("FAIL isolation: lat=%0d blk=%h want %h",
                     lat, out_block, exp);
        end
        release_block();
    endtask

    task automatic test_reset_mid();
        logic [8*NR-1:0] k;
        logic [63:0]     b;
        logic [63:0]     exp;
        logic            rdy;
        int              lat;
        accept_block(rand_kk(), rand_blk(), rdy);
        repeat (LAT / 3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_block !== 64'h0) begin
            fails++;
            $display("FAIL reset_mid_assert: vld=%b rdy=%b blk=%h want 0 0 0",
                     out_valid, in_ready, out_block);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release: rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        k   = rand_kk();
        b   = rand_blk();
        exp = model(k, b);
        accept_block(k, b, rdy);
        wait_done(lat);
        tests++;
        if (lat != LAT || out_block !== exp) begin
            fails++;
            $display("FAIL reset_mid_next: lat=%0d blk=%h want %0d %h",
                     lat, out_block, LAT, exp);
        end
        release_block();
    endtask

    task automatic test_back_to_back();
        logic [63:0]     expq [$];
        logic [8*NR-1:0] k;
        logic [63:0]     b;
        logic [63:0]     exp;
        int              sent;
        int              got;
        int              bad;
        sent = 0;
        got  = 0;
        bad  = 0;
        k    = rand_kk();
        b    = rand_blk();
        for (int cyc = 0; cyc < 8000 && got < 50; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 50);
            kk        = k;
            in_block  = b;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(model(k, b));
                sent++;
                k = rand_kk();
                b = rand_blk();
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: unexpected block %h", out_block);
                end else begin
                    exp = expq.pop_front();
                    if (out_block !== exp) begin
                        bad++;
                        $display("FAIL b2b_data%0d: got %h want %h",
                                 got, out_block, exp);
                    end
                end
                got++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_blocks: %0d bad blocks want 0", bad);
        end
        tests++;
        if (got != 50 || sent != 50) begin
            fails++;
            $display("FAIL b2b_count: sent %0d got %0d want 50 50", sent, got);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_golden();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
